// File: rtl/robo_coletor_param.sv
`default_nettype none
// ============================================================================
// Module      : robo_coletor_param
// Description : Wall-following debris-collecting robot controller.
//               Left-hand wall follower that removes debris ahead with a
//               configurable number of hits, counts forward moves and
//               cleared cells, and ends the run after MAX_MOVES moves.
//               Optional stall watchdog enabled by defining STALL_WDOG_EN.
// Ports       : clock   - single clock, rising edge
//               reset   - synchronous active-high reset
//               head    - wall ahead          left    - wall on the left
//               under   - pause request       barrier - debris ahead
//               forward/turn/remove - one-cycle registered action pulses
//               moves   - forward pulses issued (saturating)
//               cleared - debris cells removed (saturating)
//               done    - run finished (sticky)
//               stalled - run ended by the watchdog (sticky, 0 if disabled)
// Revision    : 1.0 - initial release
// ============================================================================
module robo_coletor_param #(
   parameter int CNT_W       = 24,
   parameter int MAX_MOVES   = 25,
   parameter int REMOVE_HITS = 3,
   parameter int STALL_LIM   = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             head,
   input  logic             left,
   input  logic             under,
   input  logic             barrier,
   output logic             forward,
   output logic             turn,
   output logic             remove,
   output logic [CNT_W-1:0] moves,
   output logic [CNT_W-1:0] cleared,
   output logic             done,
   output logic             stalled
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DECIDE = 3'd1,
      S_COMMIT = 3'd2,
      S_SPIN1  = 3'd3,
      S_SPIN2  = 3'd4,
      S_REMOVE = 3'd5,
      S_DONE   = 3'd6
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX     = '1;
   localparam logic [CNT_W-1:0] MAX_MOVES_C = CNT_W'(MAX_MOVES);
   localparam logic [3:0]       HITS_C      = 4'(REMOVE_HITS);

   if (REMOVE_HITS < 1 || REMOVE_HITS > 15 || STALL_LIM < 1) begin : g_bad_param
      $error("robo_coletor_param: REMOVE_HITS must be 1..15 and STALL_LIM >= 1");
   end

   state_t           state_q, state_d;
   logic             forward_q, forward_d;
   logic             turn_q, turn_d;
   logic             remove_q, remove_d;
   logic [CNT_W-1:0] moves_q, moves_d;
   logic [CNT_W-1:0] cleared_q, cleared_d;
   logic             done_q, done_d;
   logic [3:0]       hits_q, hits_d;

   // Intermediate decode of the action chosen this cycle
   logic             start_remove;
   logic             hit_pulse;
   logic             fwd_pulse;
   logic [3:0]       hit_next;
   logic [CNT_W-1:0] moves_inc;
   logic [CNT_W-1:0] cleared_inc;

`ifdef STALL_WDOG_EN
   localparam int              STALL_W   = $clog2(STALL_LIM + 1);
   localparam logic [STALL_W-1:0] STALL_LIM_C = STALL_W'(STALL_LIM);
   logic [STALL_W-1:0] stall_q, stall_d;
   logic               stalled_q, stalled_d;
   logic               wdog_active;
`endif

   always_comb begin
      state_d      = state_q;
      forward_d    = 1'b0;
      turn_d       = 1'b0;
      remove_d     = 1'b0;
      moves_d      = moves_q;
      cleared_d    = cleared_q;
      done_d       = done_q;
      hits_d       = hits_q;
      start_remove = 1'b0;
      hit_pulse    = 1'b0;
      fwd_pulse    = 1'b0;
      hit_next     = 4'd0;
      moves_inc    = (moves_q == CNT_MAX) ? moves_q : moves_q + 1'b1;
      cleared_inc  = (cleared_q == CNT_MAX) ? cleared_q : cleared_q + 1'b1;

      case (state_q)
         S_IDLE: begin
            if (!under) state_d = S_DECIDE;
         end
         S_DECIDE: begin
            if (!under) begin
               if (barrier) begin
                  start_remove = 1'b1;
               end else if (!left) begin
                  turn_d  = 1'b1;
                  state_d = S_COMMIT;
               end else if (!head) begin
                  fwd_pulse = 1'b1;
               end else begin
                  turn_d  = 1'b1;
                  state_d = S_SPIN1;
               end
            end
         end
         S_COMMIT: begin
            if (!under) begin
               if (barrier) begin
                  start_remove = 1'b1;
               end else begin
                  state_d   = S_DECIDE;
                  fwd_pulse = !head;
               end
            end
         end
         S_SPIN1: begin
            if (!under) begin
               turn_d  = 1'b1;
               state_d = S_SPIN2;
            end
         end
         S_SPIN2: begin
            if (!under) begin
               turn_d  = 1'b1;
               state_d = S_DECIDE;
            end
         end
         S_REMOVE: begin
            if (!under) begin
               if (barrier && (hits_q < HITS_C)) begin
                  hit_pulse = 1'b1;
               end else begin
                  // Debris vanished (or count already complete): abandon the cell
                  state_d = S_DECIDE;
                  hits_d  = 4'd0;
               end
            end
         end
         S_DONE: begin
            done_d = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A hit either opens a new cell (count restarts at 1) or continues one;
      // the cell is cleared on the same edge as its last hit.
      if (start_remove || hit_pulse) begin
         remove_d = 1'b1;
         hit_next = start_remove ? 4'd1 : hits_q + 4'd1;
         if (hit_next >= HITS_C) begin
            cleared_d = cleared_inc;
            hits_d    = 4'd0;
            state_d   = S_DECIDE;
         end else begin
            hits_d    = hit_next;
            state_d   = S_REMOVE;
         end
      end

      if (fwd_pulse) begin
         forward_d = 1'b1;
         moves_d   = moves_inc;
         if (moves_inc == MAX_MOVES_C) begin
            state_d = S_DONE;
            done_d  = 1'b1;
         end
      end

`ifdef STALL_WDOG_EN
      stall_d     = stall_q;
      stalled_d   = stalled_q;
      wdog_active = (state_q != S_IDLE) && (state_q != S_DONE) && !under;
      if (wdog_active) begin
         if (fwd_pulse) begin
            stall_d = '0;
         end else begin
            stall_d = stall_q + 1'b1;
            // Watchdog expiry overrides whatever this cycle would have done
            if (stall_d == STALL_LIM_C) begin
               state_d   = S_DONE;
               done_d    = 1'b1;
               stalled_d = 1'b1;
               forward_d = 1'b0;
               turn_d    = 1'b0;
               remove_d  = 1'b0;
               cleared_d = cleared_q;
               hits_d    = 4'd0;
            end
         end
      end
`endif
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= S_IDLE;
         forward_q <= 1'b0;
         turn_q    <= 1'b0;
         remove_q  <= 1'b0;
         moves_q   <= '0;
         cleared_q <= '0;
         done_q    <= 1'b0;
         hits_q    <= 4'd0;
      end else begin
         state_q   <= state_d;
         forward_q <= forward_d;
         turn_q    <= turn_d;
         remove_q  <= remove_d;
         moves_q   <= moves_d;
         cleared_q <= cleared_d;
         done_q    <= done_d;
         hits_q    <= hits_d;
      end
   end

`ifdef STALL_WDOG_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         stall_q   <= '0;
         stalled_q <= 1'b0;
      end else begin
         stall_q   <= stall_d;
         stalled_q <= stalled_d;
      end
   end
   assign stalled = stalled_q;
`else
   assign stalled = 1'b0;
`endif

   assign forward = forward_q;
   assign turn    = turn_q;
   assign remove  = remove_q;
   assign moves   = moves_q;
   assign cleared = cleared_q;
   assign done    = done_q;

endmodule
`default_nettype wire
